// File: rtl/matrix_stream_out.sv
// rtl/matrix_stream_out.sv - serialises one snapshotted matrix slot onto a byte-wide valid/ready stream
module matrix_stream_out #(
    parameter int ELEM_WIDTH = 8,
    parameter int MAX_DIM    = 5,
    parameter int MAX_MATRIX = 5,
    parameter int MAX_ELEM   = 25,
    parameter int HEADER_EN  = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [7:0]                             dimX,
    input  logic [7:0]                             dimY,
    input  logic [2:0]                             slotSel,
    input  logic [MAX_MATRIX*MAX_ELEM*ELEM_WIDTH-1:0] readData,
    input  logic [2:0]                             fillState,
    input  logic                                   outReady,
    output logic                                   outValid,
    output logic [ELEM_WIDTH-1:0]                  outData,
    output logic                                   outLast,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   error
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] DIM_MAX  = 8'(MAX_DIM);
    localparam logic [2:0] SLOT_MAX = 3'(MAX_MATRIX);
    localparam bit         HDR      = (HEADER_EN != 0);

    logic [1:0]            state;
    logic [ELEM_WIDTH-1:0] snap      [MAX_ELEM];
    logic [ELEM_WIDTH-1:0] slot_elem [MAX_ELEM];
    logic [2:0]            dim_x;
    logic [2:0]            dim_y;
    logic [2:0]            row;
    logic [2:0]            col;
    logic                  hdr_phase;

    logic                  req_ok;
    logic                  first_last;
    logic [ELEM_WIDTH-1:0] header;
    int                    sel_slot;
    logic [2:0]            nxt_row;
    logic [2:0]            nxt_col;
    logic [4:0]            nxt_idx;
    logic                  nxt_last;

    always_comb begin
        req_ok     = (dimX != 8'd0) && (dimX <= DIM_MAX) &&
                     (dimY != 8'd0) && (dimY <= DIM_MAX) &&
                     (slotSel < fillState);
        first_last = (dimX == 8'd1) && (dimY == 8'd1);
        header     = ELEM_WIDTH'({dimX[3:0], dimY[3:0]});
    end

    // Clamp the slot so the part-select never reaches past the bus on an invalid request.
    always_comb begin
        sel_slot = (slotSel < SLOT_MAX) ? int'(slotSel) : 0;
        for (int k = 0; k < MAX_ELEM; k++) begin
            slot_elem[k] = readData[(sel_slot*MAX_ELEM + k)*ELEM_WIDTH +: ELEM_WIDTH];
        end
    end

    // Position of the byte following the one currently presented; the header is followed by (0,0).
    always_comb begin
        nxt_row = row;
        nxt_col = col;
        if (hdr_phase) begin
            nxt_row = 3'd0;
            nxt_col = 3'd0;
        end else if (col == dim_y - 3'd1) begin
            nxt_col = 3'd0;
            nxt_row = row + 3'd1;
        end else begin
            nxt_col = col + 3'd1;
        end
        nxt_idx  = 5'(nxt_row) * 5'(dim_y) + 5'(nxt_col);
        nxt_last = (nxt_row == dim_x - 3'd1) && (nxt_col == dim_y - 3'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            dim_x     <= '0;
            dim_y     <= '0;
            row       <= '0;
            col       <= '0;
            hdr_phase <= 1'b0;
            outValid  <= 1'b0;
            outData   <= '0;
            outLast   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            for (int k = 0; k < MAX_ELEM; k++) begin
                snap[k] <= '0;
            end
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (req_ok) begin
                            dim_x     <= dimX[2:0];
                            dim_y     <= dimY[2:0];
                            snap      <= slot_elem;
                            row       <= '0;
                            col       <= '0;
                            hdr_phase <= HDR;
                            outData   <= HDR ? header : slot_elem[0];
                            outLast   <= HDR ? 1'b0 : first_last;
                            outValid  <= 1'b1;
                            busy      <= 1'b1;
                            state     <= S_SEND;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (outValid && outReady) begin
                        if (outLast) begin
                            outValid <= 1'b0;
                            outLast  <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            row       <= nxt_row;
                            col       <= nxt_col;
                            hdr_phase <= 1'b0;
                            outData   <= snap[nxt_idx];
                            outLast   <= nxt_last;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stream_out.sv
// tb/tb_matrix_stream_out.sv - scoreboard bench for matrix_stream_out
module tb_matrix_stream_out;

    localparam int EW = 8;
    localparam int NM = 5;
    localparam int NE = 25;
    localparam int BW = NM*NE*EW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          start0 = 1'b0;
    logic          outReady = 1'b0;
    logic [7:0]    dimX = '0;
    logic [7:0]    dimY = '0;
    logic [2:0]    slotSel = '0;
    logic [2:0]    fillState = '0;
    logic [BW-1:0] readData = '0;

    logic          ov, ol, bz, dn, er;
    logic [EW-1:0] od;
    logic          ov0, ol0, bz0, dn0, er0;
    logic [EW-1:0] od0;

    matrix_stream_out #(.HEADER_EN(1)) dut (
        .clk(clk), .rst(rst), .start(start), .dimX(dimX), .dimY(dimY),
        .slotSel(slotSel), .readData(readData), .fillState(fillState),
        .outReady(outReady), .outValid(ov), .outData(od), .outLast(ol),
        .busy(bz), .done(dn), .error(er)
    );

    matrix_stream_out #(.HEADER_EN(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .dimX(dimX), .dimY(dimY),
        .slotSel(slotSel), .readData(readData), .fillState(fillState),
        .outReady(outReady), .outValid(ov0), .outData(od0), .outLast(ol0),
        .busy(bz0), .done(dn0), .error(er0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    int   total = 0;
    int   bad = 0;
    int   done1 = 0;
    int   done0c = 0;
    int   xfer1 = 0;
    logic p1_stall = 1'b0, p0_stall = 1'b0;
    logic [7:0] p1_d, p0_d;
    logic p1_l, p0_l;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            p1_stall = 1'b0;
        end else begin
            if (dn) done1++;
            if (p1_stall) begin
                chk("hold_data", 32'(od), 32'(p1_d));
                chk("hold_last", 32'(ol), 32'(p1_l));
            end
            if (ov && outReady) begin
                total++;
                assert (q1.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_xfer observed=%0h expected=none", od);
                end
                if (q1.size() != 0) begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("data", 32'(od), 32'(e.d));
                    chk("last", 32'(ol), 32'(e.l));
                end
                xfer1++;
            end
            p1_stall = ov && !outReady;
            p1_d = od;
            p1_l = ol;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            p0_stall = 1'b0;
        end else begin
            if (dn0) done0c++;
            if (p0_stall) begin
                chk("hold_data0", 32'(od0), 32'(p0_d));
                chk("hold_last0", 32'(ol0), 32'(p0_l));
            end
            if (ov0 && outReady) begin
                total++;
                assert (q0.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_xfer0 observed=%0h expected=none", od0);
                end
                if (q0.size() != 0) begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("data0", 32'(od0), 32'(e.d));
                    chk("last0", 32'(ol0), 32'(e.l));
                end
            end
            p0_stall = ov0 && !outReady;
            p0_d = od0;
            p0_l = ol0;
        end
    end

    task automatic set_slot_seq(input int m, input int base);
        for (int k = 0; k < NE; k++) readData[(m*NE + k)*EW +: EW] = 8'(base + k);
    endtask

    task automatic set_slot_const(input int m, input logic [7:0] v);
        for (int k = 0; k < NE; k++) readData[(m*NE + k)*EW +: EW] = v;
    endtask

    task automatic set_slot_rand(input int m);
        for (int k = 0; k < NE; k++) readData[(m*NE + k)*EW +: EW] = 8'($urandom);
    endtask

    task automatic push_exp(input bit which0, input int m, input int dx, input int dy, input bit hdr);
        exp_t e;
        if (hdr) begin
            e.d = {4'(dx), 4'(dy)};
            e.l = 1'b0;
            if (which0) q0.push_back(e); else q1.push_back(e);
        end
        for (int r = 0; r < dx; r++) begin
            for (int c = 0; c < dy; c++) begin
                e.d = readData[(m*NE + r*dy + c)*EW +: EW];
                e.l = (r == dx-1) && (c == dy-1);
                if (which0) q0.push_back(e); else q1.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(input bit which0);
        @(posedge clk); #1;
        if (which0) start0 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic run_wait(input bit which0, input bit bp, input int exp_n, input string tag);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({tag, "_first_valid"}, 32'(which0 ? ov0 : ov), 32'd1);
                chk({tag, "_busy"}, 32'(which0 ? bz0 : bz), 32'd1);
            end
            if (which0 ? dn0 : dn) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (bp) outReady = (i % 4 == 0) || (i % 4 == 3);
        end
        total++;
        assert (got) else begin
            bad++;
            $error("FAIL %s_timeout observed=no_done expected=done", tag);
        end
        if (exp_n > 0) chk({tag, "_cycles"}, 32'(n), 32'(exp_n));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(which0 ? dn0 : dn), 32'd0);
        chk({tag, "_busy_after"}, 32'(which0 ? bz0 : bz), 32'd0);
        outReady = 1'b1;
    endtask

    task automatic reject(input int dx, input int dy, input int sel, input int fill, input string tag);
        dimX = 8'(dx);
        dimY = 8'(dy);
        slotSel = 3'(sel);
        fillState = 3'(fill);
        pulse_start(1'b0);
        @(negedge clk);
        chk({tag, "_err"}, 32'(er), 32'd1);
        chk({tag, "_valid"}, 32'(ov), 32'd0);
        @(negedge clk);
        chk({tag, "_err_clr"}, 32'(er), 32'd0);
        chk({tag, "_valid2"}, 32'(ov), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        int d0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(ov), 32'd0);
        chk("rst_data", 32'(od), 32'd0);
        chk("rst_last", 32'(ol), 32'd0);
        chk("rst_busy", 32'(bz), 32'd0);
        chk("rst_done", 32'(dn), 32'd0);
        chk("rst_error", 32'(er), 32'd0);
        chk("rst_valid0", 32'(ov0), 32'd0);
        rst = 1'b0;

        for (int m = 0; m < NM; m++) set_slot_rand(m);
        set_slot_seq(0, 8'h10);
        dimX = 8'd2; dimY = 8'd3; slotSel = 3'd0; fillState = 3'd1; outReady = 1'b1;
        push_exp(1'b0, 0, 2, 3, 1'b1);
        pulse_start(1'b0);
        run_wait(1'b0, 1'b0, 8, "basic");
        chk("basic_drained", 32'(q1.size()), 32'd0);

        x0 = xfer1;
        push_exp(1'b0, 0, 2, 3, 1'b1);
        pulse_start(1'b0);
        run_wait(1'b0, 1'b1, 0, "bp");
        chk("bp_xfers", 32'(xfer1 - x0), 32'd7);
        chk("bp_drained", 32'(q1.size()), 32'd0);

        reject(2, 3, 2, 2, "rej_slot");
        reject(0, 3, 0, 1, "rej_dimx");
        reject(2, 6, 0, 1, "rej_dimy");

        dimX = 8'd2; dimY = 8'd3; slotSel = 3'd0; fillState = 3'd1;
        d0 = done1;
        push_exp(1'b0, 0, 2, 3, 1'b1);
        pulse_start(1'b0);
        set_slot_const(0, 8'hFF);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run_wait(1'b0, 1'b0, 0, "snap");
        repeat (3) @(negedge clk);
        chk("snap_one_done", 32'(done1 - d0), 32'd1);
        chk("snap_idle", 32'(ov), 32'd0);
        chk("snap_drained", 32'(q1.size()), 32'd0);
        set_slot_seq(0, 8'h10);

        dimX = 8'd1; dimY = 8'd1; slotSel = 3'd0; fillState = 3'd1;
        push_exp(1'b1, 0, 1, 1, 1'b0);
        pulse_start(1'b1);
        run_wait(1'b1, 1'b0, 2, "one");
        chk("one_drained", 32'(q0.size()), 32'd0);
        chk("one_dut1_idle", 32'(ov), 32'd0);

        set_slot_rand(4);
        dimX = 8'd5; dimY = 8'd5; slotSel = 3'd4; fillState = 3'd5;
        x0 = xfer1;
        push_exp(1'b0, 4, 5, 5, 1'b1);
        pulse_start(1'b0);
        run_wait(1'b0, 1'b0, 27, "full");
        chk("full_xfers", 32'(xfer1 - x0), 32'd26);

        dimX = 8'd2; dimY = 8'd3; slotSel = 3'd0; fillState = 3'd1;
        push_exp(1'b0, 0, 2, 3, 1'b1);
        pulse_start(1'b0);
        d0 = done1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ov), 32'd0);
        chk("arst_busy", 32'(bz), 32'd0);
        chk("arst_last", 32'(ol), 32'd0);
        chk("arst_left", 32'(q1.size()), 32'd4);
        q1.delete();
        repeat (2) @(negedge clk);
        chk("arst_no_done", 32'(dn), 32'd0);
        #3 rst = 1'b0;
        chk("arst_done_cnt", 32'(done1 - d0), 32'd0);
        push_exp(1'b0, 0, 2, 3, 1'b1);
        pulse_start(1'b0);
        run_wait(1'b0, 1'b0, 8, "after_rst");
        chk("final_q1", 32'(q1.size()), 32'd0);
        chk("final_q0", 32'(q0.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
